// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM condition check, write-enable gating and split NZ/CV flag register
// Flags are evaluated as stored; updates land at the next rising edge, so an instruction never sees its own result.
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Valid,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [1:0] r_nz;
  logic [1:0] r_cv;

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;
  logic w_cond_pass;
  logic w_cond_ex;

  assign w_n  = r_nz[1];
  assign w_z  = r_nz[0];
  assign w_c  = r_cv[1];
  assign w_v  = r_cv[0];
  assign w_ge = (w_n == w_v);

  always_comb begin
    w_cond_pass = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: w_cond_pass = w_z;
      COND_NE: w_cond_pass = ~w_z;
      COND_CS: w_cond_pass = w_c;
      COND_CC: w_cond_pass = ~w_c;
      COND_MI: w_cond_pass = w_n;
      COND_PL: w_cond_pass = ~w_n;
      COND_VS: w_cond_pass = w_v;
      COND_VC: w_cond_pass = ~w_v;
      COND_HI: w_cond_pass = w_c & ~w_z;
      COND_LS: w_cond_pass = ~w_c | w_z;
      COND_GE: w_cond_pass = w_ge;
      COND_LT: w_cond_pass = ~w_ge;
      COND_GT: w_cond_pass = ~w_z & w_ge;
      COND_LE: w_cond_pass = w_z | ~w_ge;
      COND_AL: w_cond_pass = 1'b1;
      COND_NV: w_cond_pass = 1'b0;
      default: w_cond_pass = 1'b0;
    endcase
  end

  // Bubbles and stalled instructions never commit, so they can neither write nor touch flags.
  assign w_cond_ex = w_cond_pass & Valid & ~Stall;

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite = MemW & w_cond_ex;
  assign Flags    = {r_nz, r_cv};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (FlagW[1] & w_cond_ex) r_nz <= ALUFlags[3:2];
      if (FlagW[0] & w_cond_ex) r_cv <= ALUFlags[1:0];
    end
  end

endmodule
